// File: rtl/div32.sv
// Sequential unsigned restoring divider: quo = a / b, rem = a % b, one quotient
// bit per clock behind a start/busy/done handshake; b == 0 completes in one edge.
module div32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic             ge;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra top bit for the compare.
    always_comb begin
        r_shift = {r, q[WIDTH-1]};
        ge      = (r_shift >= {1'b0, d});
        q_next  = {q[WIDTH-2:0], ge};
        r_next  = ge ? (r_shift[WIDTH-1:0] - d) : r_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            quo  <= '1;
                            rem  <= a;
                            dbz  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            q     <= a;
                            d     <= b;
                            r     <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quo   <= q_next;
                        rem   <= r_next;
                        dbz   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
